bus_cycle_sequencer: RTL and testbench
======================================

Name: bus_cycle_sequencer

Overview:
- Sequences the 4-bit external data bus through the eight 4004 subcycles: A1 A2 A3 M1 M2 X1 X2 X3.
- Tracks the subcycle from clk2 rising edges and the sync marker.
- Drives the 12-bit address out in A1–A3 and captures the 8-bit instruction in M1–M2.
- Arbitrates the X2 slot between pending I/O write and I/O read requesters, supplying data_out/data_dir to the pad logic.

Parameters:
- WRITE_PRIORITY, 1, 1: write wins X2 when both pending; 0: read wins.
- WDOG_CYCLES, 64, max sysclk cycles between clk2 rising edges before watchdog trips (watchdog build only); counter width = clog2(WDOG_CYCLES+1).

Ports:
- sysclk  in  1  system clock; all state changes on its rising edge
- poc  in  1  asynchronous active-high reset (power-on clear)
- clk1  in  1  phase-1 level, sampled on sysclk
- clk2  in  1  phase-2 level, sampled on sysclk
- sync  in  1  high during X3; marks next subcycle as A1
- addr  in  12  fetch address; nibble order [3:0], [7:4], [11:8]
- bus_in  in  4  conditioned pad input
- iow_req  in  1  one-sysclk pulse: request I/O write
- iow_data  in  4  write nibble, captured with iow_req
- ior_req  in  1  one-sysclk pulse: request I/O read
- data_out  out  4  nibble driven to pad
- data_dir  out  1  1 = drive pad
- phase  out  3  current subcycle, A1=0 … X3=7
- in_hunt  out  1  1 = not locked to sync
- instr  out  8  {OPR, OPA} captured
- instr_valid  out  1  one-sysclk pulse
- iow_ack  out  1  one-sysclk pulse, write serviced
- ior_ack  out  1  one-sysclk pulse, read data valid
- rd_data  out  4  read nibble
- sync_err  out  1  one-sysclk pulse, sync missing or misplaced
- overrun  out  1  sticky: request arrived while same-type request pending
- wdog_trip  out  1  one-sysclk pulse (0 in non-watchdog builds)

Behaviour:
- Reset values (poc high, async): state HUNT; phase=0; in_hunt=1; data_out=0, data_dir=0; instr=0; rd_data=0; all pulses 0; overrun=0; pending bits and held write nibble cleared. Reset mid-cycle abandons any operation, with no ack.
- Edge event E: clk2=1 this sysclk and 0 the previous sysclk (registered clk2_d, cleared by poc). All transitions occur on the sysclk in which E is detected.
- HUNT: on E with sync=1, go to A1 and clear in_hunt. Otherwise stay in HUNT with data_dir=0.
- Locked states advance A1→…→X3 on each E.
  - At E in X3, sync=1 is required: go to A1.
  - At E in X3 with sync=0: go to HUNT and pulse sync_err.
  - sync=1 at E in any state other than X3 or HUNT: resync to A1 and pulse sync_err.
- data_dir/data_out are registered, updated at E entering the new state, and held for that subcycle:
  - A1/A2/A3: dir=1, nibbles addr[3:0], addr[7:4], addr[11:8]. addr is sampled at the E entering each A state.
  - X2 with write granted: dir=1, data_out = held write nibble.
  - All other states: dir=0, data_out unchanged.
- Capture at the E leaving the subcycle, using bus_in of that sysclk:
  - Leaving M1: instr[7:4] ← bus_in.
  - Leaving M2: instr[3:0] ← bus_in; instr_valid pulses the next sysclk.
- Requests:
  - req pulse sets a pending bit; iow_req also captures iow_data.
  - A req while the same pending bit is set: ignored, overrun ← 1 (sticky until poc).
  - Simultaneous iow_req and ior_req: both latch.
- X2 grant: decided at the E entering X2, per WRITE_PRIORITY; the loser stays pending for the next instruction cycle.
  - Write: iow_ack pulses at the E leaving X2; pending cleared.
  - Read: dir=0; rd_data ← bus_in at the E leaving X2; ior_ack pulses the same sysclk; pending cleared.
  - A req arriving in the same sysclk as the grant E is not eligible until the next X2.
- Entering HUNT: data_dir=0 immediately; pending requests are retained.

Optional Feature:
- Macro: BUS_CYCLE_SEQUENCER_WDOG_EN.
- Enabled:
  - A counter resets on each E and increments each sysclk otherwise.
  - Reaching WDOG_CYCLES while locked forces HUNT, sets data_dir=0, and pulses wdog_trip.
  - In HUNT the counter saturates with no further trips.
- Disabled: no counter; wdog_trip tied 0.

Test Plan:
- Reset then clk2 pulses with sync=1 at X3 each cycle; addr=0xA53 → data_out 3,5,A with data_dir=1 in A1–A3; phase cycles 0..7; in_hunt=0 after the first sync edge.
- bus_in 0xD in M1, 0x4 in M2 → instr=0xD4; instr_valid pulses once, one sysclk after the M2-ending E.
- iow_req (data 0x9) and ior_req in the same sysclk, WRITE_PRIORITY=1 → X2 drives 0x9 with iow_ack; next instruction X2 has dir=0, bus_in 0x6 → rd_data=6 with ior_ack.
- sync held 0 at the X3 edge → sync_err pulse, in_hunt=1, data_dir=0; sync at the next edge → A1.
- Second iow_req before X2 service → overrun=1 and stays 1; poc asserted mid-A2 → all outputs return to reset values asynchronously.
- Watchdog build, WDOG_CYCLES=64: clk2 stopped while locked → wdog_trip on the 64th sysclk, HUNT; non-watchdog build → wdog_trip stays 0.

Source files
------------

// File: rtl/bus_cycle_sequencer_if.sv
// Pad-side bundle of the 4004 bus cycle sequencer.
// slave = sequencer side, master = pad/requester side.
interface bus_cycle_sequencer_if;
    logic        clk1;
    logic        clk2;
    logic        sync;
    logic [11:0] addr;
    logic [3:0]  bus_in;
    logic        iow_req;
    logic [3:0]  iow_data;
    logic        ior_req;
    logic [3:0]  data_out;
    logic        data_dir;
    logic [2:0]  phase;
    logic        in_hunt;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        iow_ack;
    logic        ior_ack;
    logic [3:0]  rd_data;
    logic        sync_err;
    logic        overrun;
    logic        wdog_trip;

    modport slave (
        input  clk1, clk2, sync, addr, bus_in,
        input  iow_req, iow_data, ior_req,
        output data_out, data_dir, phase, in_hunt,
        output instr, instr_valid, iow_ack, ior_ack,
        output rd_data, sync_err, overrun, wdog_trip
    );

    modport master (
        output clk1, clk2, sync, addr, bus_in,
        output iow_req, iow_data, ior_req,
        input  data_out, data_dir, phase, in_hunt,
        input  instr, instr_valid, iow_ack, ior_ack,
        input  rd_data, sync_err, overrun, wdog_trip
    );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// 4004 subcycle sequencer: A1..X3 tracking, fetch and X2 I/O slot.
// BUS_CYCLE_SEQUENCER_WDOG_EN adds a clk2 watchdog.
module bus_cycle_sequencer #(
    parameter bit WRITE_PRIORITY = 1'b1,
    parameter int WDOG_CYCLES    = 64
) (
    input logic sysclk,
    input logic poc,
    bus_cycle_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        A1 = 4'd0, A2 = 4'd1, A3 = 4'd2, M1 = 4'd3,
        M2 = 4'd4, X1 = 4'd5, X2 = 4'd6, X3 = 4'd7,
        HUNT = 4'd8
    } state_t;

    state_t     state;
    logic       clk2_d;
    logic       clk2_rise;
    logic       wr_pend;
    logic       rd_pend;
    logic       gnt_w;
    logic       gnt_r;
    logic [3:0] wr_nib;
    logic       m2_done;
    logic       grant_w;
    logic       grant_r;
    logic       wd_hit;
    logic       unused_ok;

    assign clk2_rise = bus.clk2 & ~clk2_d;
    assign grant_w   = wr_pend & (WRITE_PRIORITY | ~rd_pend);
    assign grant_r   = rd_pend & ~grant_w;
    assign unused_ok = bus.clk1 ^ (WDOG_CYCLES == 0);

`ifdef BUS_CYCLE_SEQUENCER_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(WDOG_CYCLES);
    localparam logic [WDW-1:0] WD_LAST = WDW'(WDOG_CYCLES - 1);

    logic [WDW-1:0] wd_cnt;
    logic           wd_trip_q;

    // Trips on the sysclk whose increment would reach the limit.
    assign wd_hit = ~clk2_rise & (state != HUNT) & (wd_cnt == WD_LAST);
    assign bus.wdog_trip = wd_trip_q;

    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            wd_cnt    <= '0;
            wd_trip_q <= 1'b0;
        end else begin
            wd_trip_q <= wd_hit;
            if (clk2_rise)
                wd_cnt <= '0;
            else if (wd_cnt != WD_MAX)
                wd_cnt <= wd_cnt + WDW'(1);
        end
    end
`else
    assign wd_hit        = 1'b0;
    assign bus.wdog_trip = 1'b0;
`endif

    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            clk2_d          <= 1'b0;
            state           <= HUNT;
            bus.phase       <= 3'd0;
            bus.in_hunt     <= 1'b1;
            bus.data_out    <= 4'h0;
            bus.data_dir    <= 1'b0;
            bus.instr       <= 8'h00;
            bus.instr_valid <= 1'b0;
            bus.iow_ack     <= 1'b0;
            bus.ior_ack     <= 1'b0;
            bus.rd_data     <= 4'h0;
            bus.sync_err    <= 1'b0;
            bus.overrun     <= 1'b0;
            wr_pend         <= 1'b0;
            rd_pend         <= 1'b0;
            wr_nib          <= 4'h0;
            gnt_w           <= 1'b0;
            gnt_r           <= 1'b0;
            m2_done         <= 1'b0;
        end else begin
            clk2_d          <= bus.clk2;
            bus.instr_valid <= m2_done;
            m2_done         <= 1'b0;
            bus.iow_ack     <= 1'b0;
            bus.ior_ack     <= 1'b0;
            bus.sync_err    <= 1'b0;

            if (bus.iow_req) begin
                if (wr_pend) begin
                    bus.overrun <= 1'b1;
                end else begin
                    wr_pend <= 1'b1;
                    wr_nib  <= bus.iow_data;
                end
            end
            if (bus.ior_req) begin
                if (rd_pend)
                    bus.overrun <= 1'b1;
                else
                    rd_pend <= 1'b1;
            end

            if (wd_hit) begin
                state        <= HUNT;
                bus.phase    <= 3'd0;
                bus.in_hunt  <= 1'b1;
                bus.data_dir <= 1'b0;
                gnt_w        <= 1'b0;
                gnt_r        <= 1'b0;
            end else if (clk2_rise) begin
                unique case (1'b1)
                    bus.sync: begin
                        state        <= A1;
                        bus.phase    <= 3'd0;
                        bus.in_hunt  <= 1'b0;
                        bus.data_dir <= 1'b1;
                        bus.data_out <= bus.addr[3:0];
                        bus.sync_err <= (state != HUNT) && (state != X3);
                        gnt_w        <= 1'b0;
                        gnt_r        <= 1'b0;
                    end
                    !bus.sync && state == HUNT: begin
                        bus.data_dir <= 1'b0;
                    end
                    !bus.sync && state == X3: begin
                        state        <= HUNT;
                        bus.phase    <= 3'd0;
                        bus.in_hunt  <= 1'b1;
                        bus.data_dir <= 1'b0;
                        bus.sync_err <= 1'b1;
                    end
                    default: begin
                        state        <= state_t'(state + 4'd1);
                        bus.phase    <= state[2:0] + 3'd1;
                        bus.data_dir <= 1'b0;
                        unique case (state)
                            A1: begin
                                bus.data_dir <= 1'b1;
                                bus.data_out <= bus.addr[7:4];
                            end
                            A2: begin
                                bus.data_dir <= 1'b1;
                                bus.data_out <= bus.addr[11:8];
                            end
                            M1: bus.instr[7:4] <= bus.bus_in;
                            M2: begin
                                bus.instr[3:0] <= bus.bus_in;
                                m2_done        <= 1'b1;
                            end
                            X1: begin
                                gnt_w        <= grant_w;
                                gnt_r        <= grant_r;
                                bus.data_dir <= grant_w;
                                if (grant_w)
                                    bus.data_out <= wr_nib;
                            end
                            X2: begin
                                gnt_w <= 1'b0;
                                gnt_r <= 1'b0;
                                if (gnt_w) begin
                                    bus.iow_ack <= 1'b1;
                                    wr_pend     <= 1'b0;
                                end
                                if (gnt_r) begin
                                    bus.rd_data <= bus.bus_in;
                                    bus.ior_ack <= 1'b1;
                                    rd_pend     <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer: vector table plus
// hand sequences for arbitration, overrun, reset and watchdog.
module tb_bus_cycle_sequencer;
    logic sysclk = 1'b0;
    logic poc    = 1'b1;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    logic [3:0] vm, em, wm, rm;
    int   first;

    bus_cycle_sequencer_if bif();

    bus_cycle_sequencer dut (
        .sysclk(sysclk),
        .poc   (poc),
        .bus   (bif)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic        s;
        logic [3:0]  b;
        logic [11:0] a;
        logic [2:0]  ph;
        logic        dir;
        logic [3:0]  dout;
        logic        hunt;
        logic [7:0]  ins;
        logic [3:0]  vmk;
        logic [3:0]  emk;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic sub(input logic s, input logic [3:0] b);
        bif.sync   = s;
        bif.bus_in = b;
        bif.clk2   = 1'b1;
        bif.clk1   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                bif.clk2 = 1'b0;
                bif.clk1 = 1'b1;
            end
            step();
            vm[i] = bif.instr_valid;
            em[i] = bif.sync_err;
            wm[i] = bif.iow_ack;
            rm[i] = bif.ior_ack;
        end
    endtask

    task automatic run(input int n, input logic [3:0] b);
        for (int i = 0; i < n; i++)
            sub(1'b0, b);
    endtask

    task automatic req(input logic w, input logic r, input logic [3:0] d);
        bif.iow_req  = w;
        bif.ior_req  = r;
        bif.iow_data = d;
        step();
        bif.iow_req  = 1'b0;
        bif.ior_req  = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'h0, 12'hA53, 3'd0, 1'b1, 4'h3, 1'b0, 8'h00, 4'h0, 4'h0};
        tbl[1]  = '{1'b0, 4'h0, 12'hA53, 3'd1, 1'b1, 4'h5, 1'b0, 8'h00, 4'h0, 4'h0};
        tbl[2]  = '{1'b0, 4'h0, 12'hA53, 3'd2, 1'b1, 4'hA, 1'b0, 8'h00, 4'h0, 4'h0};
        tbl[3]  = '{1'b0, 4'h0, 12'hA53, 3'd3, 1'b0, 4'hA, 1'b0, 8'h00, 4'h0, 4'h0};
        tbl[4]  = '{1'b0, 4'hD, 12'hA53, 3'd4, 1'b0, 4'hA, 1'b0, 8'hD0, 4'h0, 4'h0};
        tbl[5]  = '{1'b0, 4'h4, 12'hA53, 3'd5, 1'b0, 4'hA, 1'b0, 8'hD4, 4'h2, 4'h0};
        tbl[6]  = '{1'b0, 4'h0, 12'hA53, 3'd6, 1'b0, 4'hA, 1'b0, 8'hD4, 4'h0, 4'h0};
        tbl[7]  = '{1'b0, 4'h0, 12'hA53, 3'd7, 1'b0, 4'hA, 1'b0, 8'hD4, 4'h0, 4'h0};
        tbl[8]  = '{1'b1, 4'h0, 12'h1F7, 3'd0, 1'b1, 4'h7, 1'b0, 8'hD4, 4'h0, 4'h0};
        tbl[9]  = '{1'b0, 4'h0, 12'h1F7, 3'd1, 1'b1, 4'hF, 1'b0, 8'hD4, 4'h0, 4'h0};
        tbl[10] = '{1'b0, 4'h0, 12'h1F7, 3'd2, 1'b1, 4'h1, 1'b0, 8'hD4, 4'h0, 4'h0};
        tbl[11] = '{1'b0, 4'h0, 12'h1F7, 3'd3, 1'b0, 4'h1, 1'b0, 8'hD4, 4'h0, 4'h0};
        tbl[12] = '{1'b0, 4'h3, 12'h1F7, 3'd4, 1'b0, 4'h1, 1'b0, 8'h34, 4'h0, 4'h0};
        tbl[13] = '{1'b0, 4'h8, 12'h1F7, 3'd5, 1'b0, 4'h1, 1'b0, 8'h38, 4'h2, 4'h0};
        tbl[14] = '{1'b0, 4'h0, 12'h1F7, 3'd6, 1'b0, 4'h1, 1'b0, 8'h38, 4'h0, 4'h0};
        tbl[15] = '{1'b0, 4'h0, 12'h1F7, 3'd7, 1'b0, 4'h1, 1'b0, 8'h38, 4'h0, 4'h0};
        tbl[16] = '{1'b0, 4'h0, 12'h1F7, 3'd0, 1'b0, 4'h1, 1'b1, 8'h38, 4'h0, 4'h1};
        tbl[17] = '{1'b0, 4'h0, 12'h1F7, 3'd0, 1'b0, 4'h1, 1'b1, 8'h38, 4'h0, 4'h0};
        tbl[18] = '{1'b1, 4'h0, 12'hA53, 3'd0, 1'b1, 4'h3, 1'b0, 8'h38, 4'h0, 4'h0};
        tbl[19] = '{1'b0, 4'h0, 12'hA53, 3'd1, 1'b1, 4'h5, 1'b0, 8'h38, 4'h0, 4'h0};
        tbl[20] = '{1'b1, 4'h0, 12'hA53, 3'd0, 1'b1, 4'h3, 1'b0, 8'h38, 4'h0, 4'h1};
        tbl[21] = '{1'b0, 4'h0, 12'hA53, 3'd1, 1'b1, 4'h5, 1'b0, 8'h38, 4'h0, 4'h0};

        bif.clk1 = 1'b0;
        bif.clk2 = 1'b0;
        bif.sync = 1'b0;
        bif.addr = 12'h000;
        bif.bus_in = 4'h0;
        bif.iow_req = 1'b0;
        bif.iow_data = 4'h0;
        bif.ior_req = 1'b0;

        step();
        step();
        chk("rst_phase", bif.phase, 0);
        chk("rst_hunt", bif.in_hunt, 1);
        chk("rst_dir", bif.data_dir, 0);
        chk("rst_dout", bif.data_out, 0);
        chk("rst_instr", bif.instr, 0);
        chk("rst_wdog", bif.wdog_trip, 0);
        poc = 1'b0;
        step();

        for (int i = 0; i < 22; i++) begin
            bif.addr = tbl[i].a;
            sub(tbl[i].s, tbl[i].b);
            chk($sformatf("v%0d_phase", i), bif.phase, tbl[i].ph);
            chk($sformatf("v%0d_dir", i), bif.data_dir, tbl[i].dir);
            chk($sformatf("v%0d_dout", i), bif.data_out, tbl[i].dout);
            chk($sformatf("v%0d_hunt", i), bif.in_hunt, tbl[i].hunt);
            chk($sformatf("v%0d_instr", i), bif.instr, tbl[i].ins);
            chk($sformatf("v%0d_ivalid", i), vm, tbl[i].vmk);
            chk($sformatf("v%0d_serr", i), em, tbl[i].emk);
        end

        // both requests latch together; write wins first X2
        run(2, 4'hE);
        req(1'b1, 1'b1, 4'h9);
        run(3, 4'hE);
        chk("arb_x2_phase", bif.phase, 6);
        chk("arb_x2_dir", bif.data_dir, 1);
        chk("arb_x2_dout", bif.data_out, 4'h9);
        sub(1'b0, 4'hE);
        chk("arb_wack", wm, 4'b0001);
        chk("arb_no_rack", rm, 4'b0000);
        chk("arb_x3_dir", bif.data_dir, 0);
        sub(1'b1, 4'hE);
        run(6, 4'hE);
        chk("rd_x2_phase", bif.phase, 6);
        chk("rd_x2_dir", bif.data_dir, 0);
        sub(1'b0, 4'h6);
        chk("rd_rack", rm, 4'b0001);
        chk("rd_no_wack", wm, 4'b0000);
        chk("rd_data", bif.rd_data, 4'h6);

        // overrun: second write while first still pending
        sub(1'b1, 4'hE);
        req(1'b1, 1'b0, 4'h2);
        chk("ovr_clear", bif.overrun, 0);
        req(1'b1, 1'b0, 4'h5);
        chk("ovr_set", bif.overrun, 1);
        run(6, 4'hE);
        chk("ovr_x2_dout", bif.data_out, 4'h2);
        chk("ovr_x2_dir", bif.data_dir, 1);
        sub(1'b0, 4'hE);
        chk("ovr_wack", wm, 4'b0001);
        chk("ovr_sticky", bif.overrun, 1);

        // async reset mid-A2 with a write pending
        sub(1'b1, 4'hE);
        sub(1'b0, 4'hE);
        req(1'b1, 1'b0, 4'hC);
        chk("pre_rst_dout", bif.data_out, 4'h5);
        #2;
        poc = 1'b1;
        #1;
        chk("arst_phase", bif.phase, 0);
        chk("arst_hunt", bif.in_hunt, 1);
        chk("arst_dir", bif.data_dir, 0);
        chk("arst_dout", bif.data_out, 0);
        chk("arst_instr", bif.instr, 0);
        chk("arst_rd", bif.rd_data, 0);
        chk("arst_ovr", bif.overrun, 0);
        step();
        poc = 1'b0;
        sub(1'b1, 4'hE);
        chk("post_rst_hunt", bif.in_hunt, 0);
        run(6, 4'hE);
        chk("post_rst_x2_dir", bif.data_dir, 0);
        sub(1'b0, 4'hE);
        chk("post_rst_no_wack", wm, 4'b0000);
        sub(1'b1, 4'hE);

        // clk2 stops while locked
        bif.sync = 1'b0;
        bif.clk2 = 1'b1;
        step();
        bif.clk2 = 1'b0;
        first = 0;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (bif.wdog_trip && first == 0)
                first = i;
        end
`ifdef BUS_CYCLE_SEQUENCER_WDOG_EN
        chk("wdog_cycle", first, 64);
        chk("wdog_hunt", bif.in_hunt, 1);
        chk("wdog_dir", bif.data_dir, 0);
`else
        chk("wdog_none", first, 0);
        chk("wdog_locked", bif.in_hunt, 0);
        chk("wdog_dir", bif.data_dir, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
